// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// spi_pkg : shared state type and SPI mode constants for the SPI slave PHY.
// Rev 1.0
// ============================================================================
package spi_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FRAME = 1'b1
  } spi_state_t;

  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

endpackage : spi_pkg
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// ============================================================================
// spi_sync_edge : multi-stage synchronizer with rise/fall detection.
// Rev 1.0
// ============================================================================
module spi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_dly;

  // All stages reset low, so a pin already low at reset release shows no edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= '0;
      r_dly  <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], din};
      r_dly  <= r_sync[STAGES-1];
    end
  end

  assign rise =  r_sync[STAGES-1] & ~r_dly;
  assign fall = ~r_sync[STAGES-1] &  r_dly;

endmodule : spi_sync_edge
`default_nettype wire

// File: rtl/spi_slave_driver.sv
`default_nettype none
// ============================================================================
// spi_slave_driver : SPI mode-0 slave PHY (MOSI deserializer, MISO serializer).
// Define SPI_SLAVE_ERR_EN to build the sticky partial-word err flag.
// Rev 1.0
// ============================================================================
module spi_slave_driver
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  ready,
  output logic                  start,
  output logic                  stop,
  output logic                  err,
  input  logic                  mosi,
  output logic                  miso,
  input  logic                  sclk,
  input  logic                  cs
);

  localparam int              c_cnt_w = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(DATA_WIDTH - 1);

  spi_state_t              r_state;
  spi_state_t              w_state_nxt;
  logic                    w_start_nxt;
  logic                    w_stop_nxt;
  logic [c_cnt_w-1:0]      r_bit_cnt;
  logic [DATA_WIDTH-2:0]   r_rx_shift;
  logic [DATA_WIDTH-1:0]   r_tx_shift;
  logic [DATA_WIDTH-1:0]   w_rx_word;
  logic [SYNC_STAGES-1:0]  r_mosi_sync;
  logic                    w_mosi_s;
  logic                    w_sclk_rise;
  logic                    w_sclk_fall;
  logic                    w_cs_rise;
  logic                    w_cs_fall;
  logic                    w_sample;
  logic                    w_shift;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (sclk),
    .rise (w_sclk_rise),
    .fall (w_sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_cs_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (cs),
    .rise (w_cs_rise),
    .fall (w_cs_fall)
  );

  // Same depth as the sclk chain keeps mosi aligned with the sampling edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_mosi_sync <= '0;
    else      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
  end

  assign w_mosi_s  = r_mosi_sync[SYNC_STAGES-1];
  assign w_sample  = (SPI_CPOL ^ SPI_CPHA) ? w_sclk_fall : w_sclk_rise;
  assign w_shift   = (SPI_CPOL ^ SPI_CPHA) ? w_sclk_rise : w_sclk_fall;
  assign w_rx_word = {r_rx_shift, w_mosi_s};

  always_comb begin
    w_state_nxt = r_state;
    w_start_nxt = 1'b0;
    w_stop_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_cs_fall) begin
          w_state_nxt = FRAME;
          w_start_nxt = 1'b1;
        end
      end
      FRAME: begin
        if (w_cs_rise) begin
          w_state_nxt = IDLE;
          w_stop_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // A cs rise takes priority over any sclk edge seen in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_bit_cnt  <= '0;
      r_rx_shift <= '0;
      r_tx_shift <= '0;
      data_out   <= '0;
      ready      <= 1'b0;
      start      <= 1'b0;
      stop       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      start   <= w_start_nxt;
      stop    <= w_stop_nxt;
      ready   <= 1'b0;
      if (w_start_nxt) begin
        r_tx_shift <= data_in;
        r_bit_cnt  <= '0;
      end else if (w_stop_nxt) begin
        r_bit_cnt  <= '0;
      end else if (r_state == FRAME) begin
        if (w_sample) begin
          r_rx_shift <= w_rx_word[DATA_WIDTH-2:0];
          if (r_bit_cnt == c_last) begin
            r_bit_cnt <= '0;
            data_out  <= w_rx_word;
            ready     <= 1'b1;
          end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end else if (w_shift) begin
          // Counter at zero means a word just finished: fetch the next one.
          if (r_bit_cnt == '0) r_tx_shift <= data_in;
          else                 r_tx_shift <= {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
        end
      end
    end
  end

  assign miso = (r_state == FRAME) ? r_tx_shift[DATA_WIDTH-1] : 1'b0;

`ifdef SPI_SLAVE_ERR_EN
  logic r_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                  r_err <= 1'b0;
    else if (w_start_nxt)                      r_err <= 1'b0;
    else if (w_stop_nxt && (r_bit_cnt != '0))  r_err <= 1'b1;
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule : spi_slave_driver
`default_nettype wire

// File: doc/spi_slave_driver.md
# spi_slave_driver

SPI mode-0 slave physical layer that sits between the SPI pins and `pu_slave_spi`'s buffers. It oversamples `sclk`, `cs` and `mosi` in the `clk` domain and deserializes MOSI into `DATA_WIDTH`-bit words, which it hands upstream with a one-cycle `ready` strobe. In the same frame it serializes the words that `pu_slave_spi` presents on `data_in` onto MISO. It also flags frame start and stop so the PU can frame its buffer transactions.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: bits per SPI word.
- `SYNC_STAGES`, default 2: synchronizer depth for `sclk`, `cs` and `mosi`. Minimum 2.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; asynchronous, active-low.
- `data_in`  in  `DATA_WIDTH`  next word to transmit; sampled at load points.
- `data_out`  out  `DATA_WIDTH`  last fully received word; held until the next word completes.
- `ready`  out  1  one-cycle pulse; `data_out` is updated in the same cycle.
- `start`  out  1  one-cycle pulse on a detected `cs` falling edge.
- `stop`  out  1  one-cycle pulse on a detected `cs` rising edge.
- `err`  out  1  sticky partial-word flag (see Configuration).
- `mosi`  in  1  serial data from the master.
- `miso`  out  1  serial data to the master.
- `sclk`  in  1  SPI clock; idles low.
- `cs`  in  1  chip select, active-low.

## Operation
- Mode 0 (CPOL=0, CPHA=0), MSB first.
- Every synchronizer register resets to 0, including the `cs` chain.
  - A `cs` that is already low at reset release produces no edge.
  - The block stays IDLE until `cs` goes high and then low again.
- FSM:
  - IDLE → FRAME on a `cs` fall edge: pulse `start`, load `tx_shift <= data_in`, set `bit_cnt <= 0`.
  - FRAME → IDLE on a `cs` rise edge: pulse `stop`, clear `bit_cnt`.
  - `sclk` edges are ignored in IDLE.
- On an `sclk` rise in FRAME:
  - `rx_shift <= {rx_shift[W-2:0], mosi_s}`.
  - `bit_cnt` increments and wraps from `DATA_WIDTH-1` to 0.
  - When `bit_cnt == DATA_WIDTH-1` before the increment: `data_out <= {rx_shift[W-2:0], mosi_s}` and `ready <= 1`.
- On an `sclk` fall in FRAME:
  - If `bit_cnt == 0` (a word just completed), `tx_shift <= data_in`.
  - Otherwise `tx_shift` shifts left, filling with 0.
- `miso = tx_shift[W-1]` in FRAME, 0 in IDLE.
- If `cs` rise and `sclk` rise are detected in the same cycle, the `cs` rise wins: no shift and no `ready`.
- A partial word at `cs` rise is discarded. `data_out` keeps its previous value.
- An unbounded number of words per frame is supported; the counter simply wraps.

## Timing
- Reset values: `data_out`=0, `ready`=0, `start`=0, `stop`=0, `err`=0, `miso`=0.
- Edge detection compares synchronizer stage `SYNC_STAGES` with a delayed copy.
- With `SYNC_STAGES`=2, a pin transition acts on the 3rd `clk` posedge after it. `ready`, `start` and `stop` are high for the cycle that follows.
- `data_in` rules:
  - It must be valid at the `cs` fall edge for the first word.
  - It must be updated no later than 1 cycle after `ready` for each following word. `pu_slave_spi` updates it in the `ready` cycle.
- The master must hold each `sclk` level for at least `SYNC_STAGES`+2 `clk` cycles; 4 with the defaults.
- `miso` changes 1 cycle after the synchronized `sclk` fall is detected.

## Configuration
- `SPI_SLAVE_ERR_EN` defined:
  - `err` is set when a `cs` rise is detected with `bit_cnt != 0`.
  - `err` is cleared only by `rst` or by a `start` pulse.
- `SPI_SLAVE_ERR_EN` undefined: `err` is tied to 0 and no detection logic is built.

## Structure
- Shared package `spi_pkg`:
  - state type `spi_state_t` {IDLE, FRAME};
  - constants `SPI_CPOL=0` and `SPI_CPHA=0`.
- One sub-module, `spi_sync_edge` (synchronizer plus rise/fall detector, parameterized by depth), instantiated for `sclk` and `cs`. `mosi` uses the synchronizer output only.

## Test plan
- Single-word frame: 8-bit frame with MOSI=`8'hA5`, `data_in`=`8'h3C`.
  - Expect one `start` pulse, one `ready` pulse with `data_out`=`8'hA5`, and one `stop` pulse.
  - The master captures `8'h3C`.
- Two-word frame: 16-bit frame with MOSI=`16'hA0A1`. `data_in`=`8'hB0`, and the bench switches it to `8'hB1` in the first `ready` cycle.
  - Expect two `ready` pulses with `data_out`=`A0` then `A1`.
  - The master captures `16'hB0B1`.
- Partial word: `cs` low, 5 `sclk` pulses, then `cs` high.
  - Expect no `ready`, one `stop`, and `data_out` unchanged.
  - With `SPI_SLAVE_ERR_EN`: `err`=1, and it clears on the next `start`.
- Reset mid-frame: `rst` low after 3 bits while `cs` stays low, then `rst` released.
  - All outputs are 0 and no `start` pulse is produced.
  - After `cs` goes high and then low, a full frame carrying `8'h5A` is received correctly.
- Idle behaviour: toggle `sclk` 16 times with `cs` high.
  - `miso`=0 throughout; no `ready`, `start` or `stop` pulses.
- Simultaneous `cs` rise and `sclk` rise on the last bit.
  - No `ready`; `stop` pulses.
  - With `SPI_SLAVE_ERR_EN`: `err`=1.
